instr_decoder: RTL and testbench

//  Multi-cycle decode/control block that drives the 16-bit ALU: accepts one 16-bit instruction per handshake.

---
 rtl/instr_decoder_pkg.sv | 77 +++++++
 rtl/instr_decoder_if.sv | 34 +++
 rtl/instr_decoder_lut.sv | 44 ++++
 rtl/instr_decoder.sv | 108 ++++++++++
 tb/tb_instr_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared decode definitions: opcode encodings, flag indices, FSM states, PSR masks.
package instr_decoder_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_FLAG_W     = 5;
    localparam int DEF_REG_ADDR_W = 4;

    // Flag bit positions inside alu_flags / psr_flags
    localparam int FLAG_N = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_O = 2;
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 4;

    // Major opcodes (instr[15:12])
    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_ADDCUI = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_ADDUI  = 4'h6;
    localparam logic [3:0] OP_ADDCI  = 4'h7;
    localparam logic [3:0] OP_SUBI   = 4'h9;
    localparam logic [3:0] OP_CMPI   = 4'hB;
    localparam logic [3:0] OP_CMPUI  = 4'hC;

    // R-type extended opcodes (instr[7:4])
    localparam logic [3:0] EXT_AND   = 4'h1;
    localparam logic [3:0] EXT_OR    = 4'h2;
    localparam logic [3:0] EXT_XOR   = 4'h3;
    localparam logic [3:0] EXT_ADDCU = 4'h4;
    localparam logic [3:0] EXT_ADD   = 4'h5;
    localparam logic [3:0] EXT_ADDU  = 4'h6;
    localparam logic [3:0] EXT_ADDC  = 4'h7;
    localparam logic [3:0] EXT_CMPU  = 4'h8;
    localparam logic [3:0] EXT_SUB   = 4'h9;
    localparam logic [3:0] EXT_CMP   = 4'hB;
    localparam logic [3:0] EXT_CMPUI = 4'hC;
    localparam logic [3:0] EXT_NOT   = 4'hF;

    localparam logic [7:0] ALU_CMPUI = 8'h0C;

    // PSR write masks, bit order {Z,C,O,L,N}
    localparam logic [4:0] MASK_ARITH = 5'b11101;
    localparam logic [4:0] MASK_CMP   = 5'b10011;
    localparam logic [4:0] MASK_LOGIC = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_LOGIC = 2'd1,
        CLS_ARITH = 2'd2,
        CLS_CMP   = 2'd3
    } op_class_t;

    typedef struct packed {
        logic [7:0] alu_opcode;
        op_class_t  cls;
        logic       imm_signed;
        logic       imm_sel;
        logic       legal;
    } decode_t;

    function automatic logic [4:0] psr_mask(op_class_t cls);
        case (cls)
            CLS_ARITH: psr_mask = MASK_ARITH;
            CLS_CMP:   psr_mask = MASK_CMP;
            CLS_LOGIC: psr_mask = MASK_LOGIC;
            default:   psr_mask = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Fetch handshake plus ALU / register-file control bundle around the decoder.
interface instr_decoder_if #(
    parameter int DATA_W     = 16,
    parameter int FLAG_W     = 5,
    parameter int REG_ADDR_W = 4
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [15:0]           instr;
    logic [7:0]            alu_opcode;
    logic                  alu_carry_in;
    logic [FLAG_W-1:0]     alu_flags;
    logic [REG_ADDR_W-1:0] rf_src_addr;
    logic [REG_ADDR_W-1:0] rf_dst_addr;
    logic                  imm_sel;
    logic [DATA_W-1:0]     imm_value;
    logic                  rf_we;
    logic [FLAG_W-1:0]     psr_flags;
    logic                  illegal;

    // master: fetch + datapath side
    modport master (
        output instr_valid, instr, alu_flags,
        input  instr_ready, alu_opcode, alu_carry_in, rf_src_addr, rf_dst_addr,
               imm_sel, imm_value, rf_we, psr_flags, illegal
    );

    // slave: the decoder itself
    modport slave (
        input  instr_valid, instr, alu_flags,
        output instr_ready, alu_opcode, alu_carry_in, rf_src_addr, rf_dst_addr,
               imm_sel, imm_value, rf_we, psr_flags, illegal
    );
endinterface

// File: rtl/instr_decoder_lut.sv
// Combinational instruction classifier: op/ext -> ALU opcode, class, immediate handling, legality.
module instr_decoder_lut
    import instr_decoder_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] ext,
    output decode_t    dec
);

    always_comb begin
        dec = '0;
        if (op == OP_RTYPE) begin
            dec.alu_opcode = {4'h0, ext};
            dec.legal      = 1'b1;
            case (ext)
                EXT_AND, EXT_OR, EXT_XOR, EXT_NOT:            dec.cls = CLS_LOGIC;
                EXT_ADDCU, EXT_ADD, EXT_ADDU, EXT_ADDC, EXT_SUB: dec.cls = CLS_ARITH;
                EXT_CMPU, EXT_CMP, EXT_CMPUI:                 dec.cls = CLS_CMP;
                default:                                      dec = '0;
            endcase
        end else begin
            dec.alu_opcode = {op, 4'h0};
            dec.imm_sel    = 1'b1;
            dec.legal      = 1'b1;
            case (op)
                OP_ADDCUI, OP_ADDUI:        dec.cls = CLS_ARITH;
                OP_ADDI, OP_ADDCI, OP_SUBI: begin
                    dec.cls        = CLS_ARITH;
                    dec.imm_signed = 1'b1;
                end
                OP_CMPI: begin
                    dec.cls        = CLS_CMP;
                    dec.imm_signed = 1'b1;
                end
                OP_CMPUI: begin
                    dec.cls        = CLS_CMP;
                    dec.alu_opcode = ALU_CMPUI;
                end
                default:                    dec = '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_decoder.sv
// Multi-cycle decode/control FSM for the 16-bit ALU: IDLE -> DECODE -> EXEC -> WB, owns the PSR.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FLAG_W     = DEF_FLAG_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    instr_decoder_if.slave bus
);

    state_t                state, state_nxt;
    decode_t               dec;
    op_class_t             cls_q;
    logic                  accept;
    logic [FLAG_W-1:0]     mask;

    logic [7:0]            alu_opcode_q;
    logic [REG_ADDR_W-1:0] src_q, dst_q;
    logic                  imm_sel_q;
    logic [DATA_W-1:0]     imm_q;
    logic                  rf_we_q;
    logic                  illegal_q;
    logic [FLAG_W-1:0]     psr_q;

    instr_decoder_lut u_lut (
        .op  (bus.instr[15:12]),
        .ext (bus.instr[7:4]),
        .dec (dec)
    );

    assign accept = (state == ST_IDLE) && !reset && bus.instr_valid;
    assign mask   = FLAG_W'(psr_mask(cls_q));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (cls_q == CLS_NONE) ? ST_IDLE : ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cls_q        <= CLS_NONE;
            alu_opcode_q <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            imm_sel_q    <= 1'b0;
            imm_q        <= '0;
            rf_we_q      <= 1'b0;
            illegal_q    <= 1'b0;
            psr_q        <= '0;
        end else begin
            state     <= state_nxt;
            rf_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                // Load the output registers on the accept edge so they are visible during DECODE.
                ST_IDLE: if (accept) begin
                    cls_q <= dec.cls;
                    if (dec.legal) begin
                        alu_opcode_q <= dec.alu_opcode;
                        dst_q        <= bus.instr[11:8];
                        src_q        <= dec.imm_sel ? '0 : bus.instr[3:0];
                        imm_sel_q    <= dec.imm_sel;
                        if (dec.imm_sel)
                            imm_q <= dec.imm_signed ? {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]}
                                                    : {{(DATA_W-8){1'b0}}, bus.instr[7:0]};
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    psr_q   <= (psr_q & ~mask) | (bus.alu_flags & mask);
                    rf_we_q <= (cls_q != CLS_CMP);
                end
                ST_WB: begin
                    cls_q        <= CLS_NONE;
                    alu_opcode_q <= '0;
                    src_q        <= '0;
                    dst_q        <= '0;
                    imm_sel_q    <= 1'b0;
                    imm_q        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready  = (state == ST_IDLE) && !reset;
    assign bus.alu_opcode   = alu_opcode_q;
    assign bus.alu_carry_in = psr_q[FLAG_C];
    assign bus.rf_src_addr  = src_q;
    assign bus.rf_dst_addr  = dst_q;
    assign bus.imm_sel      = imm_sel_q;
    assign bus.imm_value    = imm_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.psr_flags    = psr_q;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed test of instr_decoder: decode fields, PSR masking, carry feedback, illegal, reset, throughput.
module tb_instr_decoder;

    logic clk = 1'b0;
    logic reset;
    int   n_run = 0;
    int   n_fail = 0;

    instr_decoder_if #(.DATA_W(16), .FLAG_W(5), .REG_ADDR_W(4)) bus ();

    instr_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Returns at the negedge of the DECODE cycle (T+1).
    task automatic send(input logic [15:0] i);
        int w = 0;
        while (!bus.instr_ready && w < 20) begin
            step();
            w++;
        end
        chk("ready_wait", 32'(bus.instr_ready), 32'd1);
        bus.instr       = i;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
    endtask

    int acc;

    initial begin
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.alu_flags   = '0;
        step(); step();
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_opcode", 32'(bus.alu_opcode), 32'h00);
        chk("rst_psr", 32'(bus.psr_flags), 32'h00);
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(bus.instr_ready), 32'd1);

        // ADD r3,r5 ; PSR <- 01100 through arithmetic mask
        bus.alu_flags = 5'b01100;
        send(16'h0355);
        chk("add_dec_illegal", 32'(bus.illegal), 32'd0);
        chk("add_dec_ready", 32'(bus.instr_ready), 32'd0);
        step();
        chk("add_opcode", 32'(bus.alu_opcode), 32'h05);
        chk("add_dst", 32'(bus.rf_dst_addr), 32'd3);
        chk("add_src", 32'(bus.rf_src_addr), 32'd5);
        chk("add_immsel", 32'(bus.imm_sel), 32'd0);
        chk("add_exec_we", 32'(bus.rf_we), 32'd0);
        step();
        chk("add_wb_we", 32'(bus.rf_we), 32'd1);
        chk("add_psr", 32'(bus.psr_flags), 32'h0C);
        chk("add_wb_ready", 32'(bus.instr_ready), 32'd0);
        step();
        chk("add_idle_ready", 32'(bus.instr_ready), 32'd1);
        chk("add_idle_opcode", 32'(bus.alu_opcode), 32'h00);
        chk("add_idle_we", 32'(bus.rf_we), 32'd0);

        // ADDI r2,#-3 (sign-extended)
        send(16'h52FD);
        step();
        chk("addi_opcode", 32'(bus.alu_opcode), 32'h50);
        chk("addi_immsel", 32'(bus.imm_sel), 32'd1);
        chk("addi_imm", 32'(bus.imm_value), 32'hFFFD);
        chk("addi_dst", 32'(bus.rf_dst_addr), 32'd2);
        chk("addi_src", 32'(bus.rf_src_addr), 32'd0);
        step(); step();
        chk("addi_idle_imm", 32'(bus.imm_value), 32'h0000);

        // ADDUI r1,#FD (zero-extended)
        send(16'h61FD);
        step();
        chk("addui_opcode", 32'(bus.alu_opcode), 32'h60);
        chk("addui_imm", 32'(bus.imm_value), 32'h00FD);
        step(); step();

        // CMP r4,r1 with PSR=01100 and flags 10011 -> 11111, no write
        chk("cmp_pre_psr", 32'(bus.psr_flags), 32'h0C);
        bus.alu_flags = 5'b10011;
        send(16'h04B1);
        step();
        chk("cmp_opcode", 32'(bus.alu_opcode), 32'h0B);
        step();
        chk("cmp_psr", 32'(bus.psr_flags), 32'h1F);
        chk("cmp_we", 32'(bus.rf_we), 32'd0);
        step();
        chk("cmp_idle_we", 32'(bus.rf_we), 32'd0);

        // CMPUI r3,#80: zero-extended, compare class
        bus.alu_flags = 5'b00000;
        send(16'hC380);
        step();
        chk("cmpui_opcode", 32'(bus.alu_opcode), 32'h0C);
        chk("cmpui_imm", 32'(bus.imm_value), 32'h0080);
        step();
        chk("cmpui_we", 32'(bus.rf_we), 32'd0);
        chk("cmpui_psr", 32'(bus.psr_flags), 32'h0C);
        step();

        // ADD sets C (psr = 01100&00010 | 01000 = 01000), then ADDC sees carry_in=1
        bus.alu_flags = 5'b01000;
        send(16'h0355);
        step(); step(); step();
        chk("carry_psr", 32'(bus.psr_flags), 32'h08);
        bus.alu_flags = 5'b00000;
        send(16'h0172);
        chk("addc_dec_cin", 32'(bus.alu_carry_in), 32'd1);
        step();
        chk("addc_opcode", 32'(bus.alu_opcode), 32'h07);
        chk("addc_exec_cin", 32'(bus.alu_carry_in), 32'd1);
        @(posedge clk); #4;
        chk("addc_exec_cin_late", 32'(bus.alu_carry_in), 32'd0);
        step();
        chk("addc_wb_cin", 32'(bus.alu_carry_in), 32'd0);
        chk("addc_psr", 32'(bus.psr_flags), 32'h00);
        step();

        // Illegal R-type ext E and op F
        bus.alu_flags = 5'b11111;
        send(16'h00E0);
        chk("ill_e_pulse", 32'(bus.illegal), 32'd1);
        chk("ill_e_we", 32'(bus.rf_we), 32'd0);
        chk("ill_e_opcode", 32'(bus.alu_opcode), 32'h00);
        step();
        chk("ill_e_clear", 32'(bus.illegal), 32'd0);
        chk("ill_e_ready", 32'(bus.instr_ready), 32'd1);
        chk("ill_e_psr", 32'(bus.psr_flags), 32'h00);
        send(16'hF000);
        chk("ill_f_pulse", 32'(bus.illegal), 32'd1);
        step();
        chk("ill_f_ready", 32'(bus.instr_ready), 32'd1);
        chk("ill_f_we", 32'(bus.rf_we), 32'd0);

        // Reset during EXEC drops the pending write and clears PSR
        send(16'h0355);
        step();
        chk("rst_mid_exec_op", 32'(bus.alu_opcode), 32'h05);
        reset = 1'b1;
        step();
        chk("rst_mid_opcode", 32'(bus.alu_opcode), 32'h00);
        chk("rst_mid_psr", 32'(bus.psr_flags), 32'h00);
        chk("rst_mid_we", 32'(bus.rf_we), 32'd0);
        chk("rst_mid_ready", 32'(bus.instr_ready), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_after_we", 32'(bus.rf_we), 32'd0);
        chk("rst_after_ready", 32'(bus.instr_ready), 32'd1);
        step();
        chk("rst_after_we2", 32'(bus.rf_we), 32'd0);

        // Continuous instr_valid: accepted once every 4 cycles
        acc = 0;
        bus.alu_flags   = 5'b00000;
        bus.instr       = 16'h0355;
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.instr_ready) begin
                acc++;
                chk($sformatf("b2b_slot%0d", c), 32'(c % 4), 32'd0);
            end
            step();
        end
        bus.instr_valid = 1'b0;
        chk("b2b_count", 32'(acc), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
